control_unit_mc: RTL and testbench

Multicycle control unit for the RV32I load-store datapath. It sequences fetch, decode, execute, memory and write-back from the instruction register's opcode fields. It drives every datapath control input (`sub`, `ULA_din2_sel`, `RF_din_sel`, `WE_RF`, `WE_MEM`, `load_pc`, `pc_next_sel`, `pc_adder_sel`, `load_ir`) that test benches previously drove by hand. It generalises that sequencing with configurable instruction/data memory latencies and a retired-instruction counter.

---
 rtl/control_unit_mc_if.sv | 32 +++
 rtl/control_unit_mc.sv | 201 ++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_mc_if.sv
// Datapath control bundle for control_unit_mc: decoded IR fields and zero flag in,
// datapath enables/selects out. The control unit uses the master modport.
`timescale 1ns/1ps

interface control_unit_mc_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       load_ir;
    logic       load_pc;
    logic       pc_next_sel;
    logic       pc_adder_sel;
    logic       ULA_din2_sel;
    logic       sub;
    logic [1:0] RF_din_sel;
    logic       WE_RF;
    logic       WE_MEM;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7b5, zero,
        output load_ir, load_pc, pc_next_sel, pc_adder_sel, ULA_din2_sel,
               sub, RF_din_sel, WE_RF, WE_MEM, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  load_ir, load_pc, pc_next_sel, pc_adder_sel, ULA_din2_sel,
               sub, RF_din_sel, WE_RF, WE_MEM, illegal
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// configurable memory latencies. Define CONTROL_BRANCH_EN to enable BEQ/BNE.
`timescale 1ns/1ps

module control_unit_mc #(
    parameter int unsigned IMEM_LATENCY = 1,
    parameter int unsigned DMEM_LATENCY = 1,
    parameter int unsigned COUNT_WIDTH  = 32
) (
    input  logic                   CLK,
    input  logic                   reset,
    control_unit_mc_if.master      bus,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam int unsigned MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
    localparam int unsigned LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [LAT_W-1:0] I_LAST = LAT_W'(IMEM_LATENCY - 1);
    localparam logic [LAT_W-1:0] D_LAST = LAT_W'(DMEM_LATENCY - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
`ifdef CONTROL_BRANCH_EN
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
`endif

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic                   illegal_q, illegal_d;
    logic                   run_q, run_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic       legal;
    logic       load_ir_c, load_pc_c, pc_next_sel_c, pc_adder_sel_c;
    logic       ula_sel_c, sub_c, we_rf_c, we_mem_c;
    logic [1:0] rf_sel_c;

`ifndef CONTROL_BRANCH_EN
    logic unused_zero;
    assign unused_zero = bus.zero;
`endif

    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            OPC_OP, OPC_IMM, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE:
                legal = 1'b1;
`ifdef CONTROL_BRANCH_EN
            OPC_BRANCH:
                legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        lat_d          = lat_q;
        illegal_d      = illegal_q;
        run_d          = 1'b1;
        load_ir_c      = 1'b0;
        load_pc_c      = 1'b0;
        pc_next_sel_c  = 1'b0;
        pc_adder_sel_c = 1'b0;
        ula_sel_c      = 1'b0;
        sub_c          = 1'b0;
        rf_sel_c       = 2'd0;
        we_rf_c        = 1'b0;
        we_mem_c       = 1'b0;

        // The partial cycle between reset release and the next edge is idle,
        // so the first real FETCH cycle starts on that edge.
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    if (lat_q == I_LAST) begin
                        load_ir_c = 1'b1;
                        lat_d     = '0;
                        state_d   = DECODE;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                DECODE: begin
                    if (legal) begin
                        state_d = EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                end
                EXEC: begin
                    state_d = FETCH;
                    case (bus.opcode)
                        OPC_OP: begin
                            sub_c     = bus.funct7b5 & (bus.funct3 == 3'b000);
                            rf_sel_c  = 2'd1;
                            we_rf_c   = 1'b1;
                            load_pc_c = 1'b1;
                        end
                        OPC_IMM: begin
                            ula_sel_c = 1'b1;
                            rf_sel_c  = 2'd1;
                            we_rf_c   = 1'b1;
                            load_pc_c = 1'b1;
                        end
                        OPC_AUIPC: begin
                            pc_adder_sel_c = 1'b1;
                            rf_sel_c       = 2'd3;
                            we_rf_c        = 1'b1;
                            load_pc_c      = 1'b1;
                        end
                        OPC_JAL, OPC_JALR: begin
                            pc_adder_sel_c = (bus.opcode == OPC_JAL);
                            pc_next_sel_c  = 1'b1;
                            rf_sel_c       = 2'd2;
                            we_rf_c        = 1'b1;
                            load_pc_c      = 1'b1;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            ula_sel_c = 1'b1;
                            state_d   = MEM;
                        end
`ifdef CONTROL_BRANCH_EN
                        OPC_BRANCH: begin
                            sub_c          = 1'b1;
                            pc_adder_sel_c = 1'b1;
                            pc_next_sel_c  = (bus.funct3 == 3'b000) ? bus.zero : !bus.zero;
                            load_pc_c      = 1'b1;
                        end
`endif
                        default: state_d = HALT;
                    endcase
                end
                MEM: begin
                    ula_sel_c = 1'b1;
                    if (lat_q == D_LAST) begin
                        lat_d = '0;
                        if (bus.opcode == OPC_STORE) begin
                            we_mem_c  = 1'b1;
                            load_pc_c = 1'b1;
                            state_d   = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                WB: begin
                    rf_sel_c  = 2'd0;
                    we_rf_c   = 1'b1;
                    load_pc_c = 1'b1;
                    state_d   = FETCH;
                end
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end

        count_d = load_pc_c ? count_q + COUNT_WIDTH'(1) : count_q;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            lat_q     <= '0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            illegal_q <= illegal_d;
            run_q     <= run_d;
            count_q   <= count_d;
        end
    end

    assign bus.load_ir      = load_ir_c;
    assign bus.load_pc      = load_pc_c;
    assign bus.pc_next_sel  = pc_next_sel_c;
    assign bus.pc_adder_sel = pc_adder_sel_c;
    assign bus.ULA_din2_sel = ula_sel_c;
    assign bus.sub          = sub_c;
    assign bus.RF_din_sel   = rf_sel_c;
    assign bus.WE_RF        = we_rf_c;
    assign bus.WE_MEM       = we_mem_c;
    assign bus.illegal      = illegal_q;
    assign instr_count      = count_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: table of instructions expanded into per-cycle
// expected control vectors, plus reset/illegal/wrap sequences.
`timescale 1ns/1ps

module tb_control_unit_mc;

    typedef logic [10:0] ctl_t;   // {illegal, load_ir, load_pc, pc_next, pc_adder, ula2, sub, rf[1:0], we_rf, we_mem}

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         kind;         // 0 = single EXEC, 1 = load, 2 = store
        ctl_t       exec;
    } vec_t;

    localparam ctl_t C_ILLEGAL = 11'h400;
    localparam ctl_t C_LOAD_IR = 11'h200;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    control_unit_mc_if if1 ();
    control_unit_mc_if if2 ();
    logic [2:0]  cnt1;
    logic [31:0] cnt2;

    control_unit_mc #(.IMEM_LATENCY(1), .DMEM_LATENCY(3), .COUNT_WIDTH(3)) u1 (
        .CLK(CLK), .reset(reset), .bus(if1), .instr_count(cnt1));
    control_unit_mc #(.IMEM_LATENCY(3), .DMEM_LATENCY(2), .COUNT_WIDTH(32)) u2 (
        .CLK(CLK), .reset(reset), .bus(if2), .instr_count(cnt2));

    ctl_t obs1, obs2;
    assign obs1 = {if1.illegal, if1.load_ir, if1.load_pc, if1.pc_next_sel, if1.pc_adder_sel,
                   if1.ULA_din2_sel, if1.sub, if1.RF_din_sel, if1.WE_RF, if1.WE_MEM};
    assign obs2 = {if2.illegal, if2.load_ir, if2.load_pc, if2.pc_next_sel, if2.pc_adder_sel,
                   if2.ULA_din2_sel, if2.sub, if2.RF_din_sel, if2.WE_RF, if2.WE_MEM};

    int   errors = 0;
    int   checks = 0;
    int   cnt_exp1 = 0;
    int   cnt_exp2 = 0;
    ctl_t exp_q[$];
    vec_t tbl[$];

    function automatic ctl_t mk(logic lp, logic pn, logic pa, logic ula, logic sb,
                                logic [1:0] rf, logic wr, logic wm);
        return {1'b0, 1'b0, lp, pn, pa, ula, sb, rf, wr, wm};
    endfunction

    function automatic vec_t rec(string name, logic [6:0] op, logic [2:0] f3, logic f7,
                                 logic z, int kind, ctl_t exec);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.kind = kind; v.exec = exec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic drive(input int d, input vec_t v);
        if (d == 1) begin
            if1.opcode = v.op; if1.funct3 = v.f3; if1.funct7b5 = v.f7; if1.zero = v.z;
        end else begin
            if2.opcode = v.op; if2.funct3 = v.f3; if2.funct7b5 = v.f7; if2.zero = v.z;
        end
    endtask

    task automatic push_fetch_decode(input int d);
        int unsigned il;
        il = (d == 1) ? 1 : 3;
        for (int unsigned i = 0; i + 1 < il; i++) exp_q.push_back('0);
        exp_q.push_back(C_LOAD_IR);
        exp_q.push_back('0);
    endtask

    task automatic push_trace(input int d, input vec_t v);
        int unsigned dl;
        dl = (d == 1) ? 3 : 2;
        push_fetch_decode(d);
        exp_q.push_back(v.exec);
        if (v.kind == 1) begin
            for (int unsigned i = 0; i < dl; i++) exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd0, 0, 0));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0, 1, 0));
        end else if (v.kind == 2) begin
            for (int unsigned i = 0; i + 1 < dl; i++) exp_q.push_back(mk(0, 0, 0, 1, 0, 2'd0, 0, 0));
            exp_q.push_back(mk(1, 0, 0, 1, 0, 2'd0, 0, 1));
        end
    endtask

    task automatic drain(input int d, input string nm);
        int   k;
        ctl_t e;
        k = 1;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            chk($sformatf("%s ctl cycle %0d", nm, k), 32'((d == 1) ? obs1 : obs2), 32'(e));
            k++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic run(input int d, input vec_t v);
        drive(d, v);
        push_trace(d, v);
        drain(d, v.name);
        if (d == 1) begin
            cnt_exp1++;
            chk({v.name, " count"}, 32'(cnt1), 32'(cnt_exp1 % 8));
        end else begin
            cnt_exp2++;
            chk({v.name, " count"}, cnt2, 32'(cnt_exp2));
        end
    endtask

    task automatic run_illegal(input string nm, input logic [6:0] op, input logic [2:0] f3);
        vec_t v;
        v = rec(nm, op, f3, 1'b0, 1'b1, 0, '0);
        drive(1, v);
        push_fetch_decode(1);
        for (int i = 0; i < 20; i++) exp_q.push_back(C_ILLEGAL);
        drain(1, nm);
        chk({nm, " count"}, 32'(cnt1), 32'(cnt_exp1 % 8));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge CLK);
        chk("reset outputs u1", 32'(obs1), 32'd0);
        chk("reset outputs u2", 32'(obs2), 32'd0);
        chk("reset count u1", 32'(cnt1), 32'd0);
        chk("reset count u2", cnt2, 32'd0);
        #1 reset = 1'b0;
        #1 chk("idle after release", 32'(obs1), 32'd0);
        @(posedge CLK); #1;
        cnt_exp1 = 0;
        cnt_exp2 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if1.opcode = 7'b0000000; if1.funct3 = '0; if1.funct7b5 = 1'b0; if1.zero = 1'b0;
        if2.opcode = 7'b0110011; if2.funct3 = '0; if2.funct7b5 = 1'b0; if2.zero = 1'b0;

        tbl.push_back(rec("ADD",   7'b0110011, 3'b000, 1'b0, 1'b0, 0, mk(1, 0, 0, 0, 0, 2'd1, 1, 0)));
        tbl.push_back(rec("SUB",   7'b0110011, 3'b000, 1'b1, 1'b0, 0, mk(1, 0, 0, 0, 1, 2'd1, 1, 0)));
        tbl.push_back(rec("SRA",   7'b0110011, 3'b101, 1'b1, 1'b0, 0, mk(1, 0, 0, 0, 0, 2'd1, 1, 0)));
        tbl.push_back(rec("ADDI",  7'b0010011, 3'b000, 1'b1, 1'b0, 0, mk(1, 0, 0, 1, 0, 2'd1, 1, 0)));
        tbl.push_back(rec("AUIPC", 7'b0010111, 3'b000, 1'b0, 1'b0, 0, mk(1, 0, 1, 0, 0, 2'd3, 1, 0)));
        tbl.push_back(rec("JAL",   7'b1101111, 3'b000, 1'b0, 1'b0, 0, mk(1, 1, 1, 0, 0, 2'd2, 1, 0)));
        tbl.push_back(rec("JALR",  7'b1100111, 3'b000, 1'b0, 1'b0, 0, mk(1, 1, 0, 0, 0, 2'd2, 1, 0)));
        tbl.push_back(rec("LOAD",  7'b0000011, 3'b010, 1'b0, 1'b0, 1, mk(0, 0, 0, 1, 0, 2'd0, 0, 0)));
        tbl.push_back(rec("STORE", 7'b0100011, 3'b010, 1'b0, 1'b0, 2, mk(0, 0, 0, 1, 0, 2'd0, 0, 0)));
`ifdef CONTROL_BRANCH_EN
        tbl.push_back(rec("BEQ z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, mk(1, 1, 1, 0, 1, 2'd0, 0, 0)));
        tbl.push_back(rec("BEQ z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, mk(1, 0, 1, 0, 1, 2'd0, 0, 0)));
        tbl.push_back(rec("BNE z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 0, mk(1, 1, 1, 0, 1, 2'd0, 0, 0)));
        tbl.push_back(rec("BNE z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, mk(1, 0, 1, 0, 1, 2'd0, 0, 0)));
`endif

        repeat (2) @(posedge CLK);
        #1;
        do_reset();
        foreach (tbl[i]) run(1, tbl[i]);

        do_reset();
        for (int i = 0; i < 9; i++) run(1, tbl[0]);
        chk("wrap after 9 ADDs", 32'(cnt1), 32'd1);

        do_reset();
        run_illegal("illegal opcode", 7'b0000000, 3'b000);
        do_reset();
`ifdef CONTROL_BRANCH_EN
        run_illegal("BLT unsupported", 7'b1100011, 3'b100);
`else
        run_illegal("branch disabled", 7'b1100011, 3'b000);
`endif
        do_reset();
        run(1, tbl[0]);

        // Reset asserted while the STORE is in its last MEM cycle.
        do_reset();
        run(1, tbl[0]);
        drive(1, tbl[8]);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("store WE_MEM before reset", 32'(if1.WE_MEM), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async WE_MEM drop", 32'(if1.WE_MEM), 32'd0);
        chk("async load_pc drop", 32'(if1.load_pc), 32'd0);
        chk("async all outputs", 32'(obs1), 32'd0);
        @(posedge CLK); #1;
        chk("count cleared by reset", 32'(cnt1), 32'd0);
        @(negedge CLK);
        #1 reset = 1'b0;
        @(posedge CLK); #1;
        cnt_exp1 = 0;
        cnt_exp2 = 0;
        run(1, tbl[0]);

        do_reset();
        run(2, tbl[0]);
        run(2, tbl[7]);
        run(2, tbl[8]);
        run(2, tbl[5]);
        run(2, tbl[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
